// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the 3-stage RV32I pipeline sequencing logic:
// opcodes, PC mux select encodings and hazard-controller FSM states.
// Imported by pipe_hazard_ctrl and pipe_hazard_ctrl_reg_use_decode.
package pipe_hazard_ctrl_pkg;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;

  // PC mux selects driven onto pc_sel
  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_ALU  = 2'd1;
  localparam logic [1:0] PC_SEL_RST  = 2'd2;
  localparam logic [1:0] PC_SEL_HOLD = 2'd3;

  // Hazard controller states
  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LDUSE = 2'd2
  } hz_state_t;

  // True when rd is a real architectural destination (x0 is hardwired zero)
  function automatic logic is_real_reg(input logic [4:0] r);
    return (r != 5'd0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_reg_use_decode.sv
// Register-usage decoder: extracts rd/rs1/rs2 fields of an RV32I
// instruction and flags which source fields the instruction actually reads.
// Purely combinational; instantiated once for D and once for X.
module pipe_hazard_ctrl_reg_use_decode
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_unused_hi;

  assign w_opcode = inst[6:0];
  assign w_funct3 = inst[14:12];
  assign rd       = inst[11:7];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];

  // funct7 / upper immediate bits never affect register usage
  assign w_unused_hi = ^inst[31:25];

  // Per-opcode source usage; CSR immediate forms (funct3[2]=1) carry uimm in rs1
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (w_opcode)
      OPC_ARI_RTYPE,
      OPC_BRANCH,
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_ARI_ITYPE,
      OPC_LOAD,
      OPC_JALR: begin
        uses_rs1 = 1'b1;
      end
      OPC_CSR: begin
        uses_rs1 = ~w_funct3[2];
      end
      default: begin
        // lui, auipc, jal and unknown encodings read no registers
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 3-stage RV32I pipeline (F/D, X, W).
// Produces PC select, D-stage hold, X-stage bubble and W->X forwarding
// selects, and owns the cycle/instret performance counters.
// Optional: define HAZARD_BUBBLE_CNT_EN to add the bubble_cnt output,
// counting RUN-state cycles in which a bubble is injected into X.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      d_inst,
  input  logic [31:0]      x_inst,
  input  logic             x_valid,
  input  logic             x_redirect,
  input  logic             w_valid,
  input  logic             w_reg_wen,
  input  logic [4:0]       w_rd,
  input  logic             cnt_clr,
  output logic [1:0]       pc_sel,
  output logic             stall_d,
  output logic             kill_x,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`ifdef HAZARD_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  hz_state_t          r_state;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic [CNT_W-1:0]   r_instret_cnt;

  logic [4:0] w_d_rd_unused;
  logic [4:0] w_d_rs1;
  logic [4:0] w_d_rs2;
  logic       w_d_uses_rs1;
  logic       w_d_uses_rs2;
  logic [4:0] w_x_rd;
  logic [4:0] w_x_rs1;
  logic [4:0] w_x_rs2;
  logic       w_x_uses_rs1;
  logic       w_x_uses_rs2;

  logic       w_redirect;
  logic       w_load_use;
  logic       w_w_fwd_ok;

  // D-stage usage: who the incoming instruction depends on
  pipe_hazard_ctrl_reg_use_decode u_dec_d (
    .inst     (d_inst),
    .rd       (w_d_rd_unused),
    .rs1      (w_d_rs1),
    .rs2      (w_d_rs2),
    .uses_rs1 (w_d_uses_rs1),
    .uses_rs2 (w_d_uses_rs2)
  );

  // X-stage usage: load destination and forwarding consumers
  pipe_hazard_ctrl_reg_use_decode u_dec_x (
    .inst     (x_inst),
    .rd       (w_x_rd),
    .rs1      (w_x_rs1),
    .rs2      (w_x_rs2),
    .uses_rs1 (w_x_uses_rs1),
    .uses_rs2 (w_x_uses_rs2)
  );

  // A taken control transfer only counts when X holds a real instruction
  assign w_redirect = x_valid & x_redirect;

  // A load in X whose result D needs next cycle cannot be forwarded in time
  assign w_load_use = (x_inst[6:0] == OPC_LOAD) & is_real_reg(w_x_rd) &
                      ((w_d_uses_rs1 & (w_d_rs1 == w_x_rd)) |
                       (w_d_uses_rs2 & (w_d_rs2 == w_x_rd)));

  // Retiring W write that is eligible to feed X (x0 never forwarded)
  assign w_w_fwd_ok = w_valid & w_reg_wen & is_real_reg(w_rd);

  // Output decode from current state and live inputs
  always_comb begin
    pc_sel  = PC_SEL_PC4;
    stall_d = 1'b0;
    kill_x  = 1'b0;
    fwd_a   = 1'b0;
    fwd_b   = 1'b0;
    if (rst) begin
      pc_sel = PC_SEL_RST;
      kill_x = 1'b1;
    end else begin
      case (r_state)
        ST_HOLD: begin
          // Present the reset vector once, then let PC+4 stream while IMEM warms up
          pc_sel = (r_hold_cnt == '0) ? PC_SEL_RST : PC_SEL_PC4;
          kill_x = 1'b1;
        end
        ST_RUN: begin
          if (w_redirect) begin
            // Redirect beats load-use: the D instruction is on the wrong path
            pc_sel = PC_SEL_ALU;
            kill_x = 1'b1;
          end else if (w_load_use) begin
            pc_sel  = PC_SEL_HOLD;
            stall_d = 1'b1;
            kill_x  = 1'b1;
          end
        end
        ST_LDUSE: begin
          // Dependent instruction advances; load is now in W and forwards
          pc_sel = PC_SEL_PC4;
        end
        default: begin
          pc_sel = PC_SEL_PC4;
        end
      endcase
      fwd_a = w_w_fwd_ok & w_x_uses_rs1 & (w_rd == w_x_rs1);
      fwd_b = w_w_fwd_ok & w_x_uses_rs2 & (w_rd == w_x_rs2);
    end
  end

  // Sequencing FSM: post-reset hold window, normal run, one-cycle load-use stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RUN;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_redirect && w_load_use) begin
            r_state <= ST_LDUSE;
          end
        end
        ST_LDUSE: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

  // Performance counters; clear wins over increment, both wrap naturally
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_valid) begin
        r_instret_cnt <= r_instret_cnt + 1'b1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

`ifdef HAZARD_BUBBLE_CNT_EN
  logic [CNT_W-1:0] r_bubble_cnt;

  // Count bubbles injected while running; HOLD-window kills are excluded
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_bubble_cnt <= '0;
    end else if ((r_state == ST_RUN) && kill_x) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
